// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the framebuffer scanline arbiter.
// A line base is line_idx*160, built as (line_idx<<7)+(line_idx<<5).
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  localparam int WORDS_PER_LINE   = 160;
  localparam int LB_ADDR_W        = 9;
  localparam int WORD_IDX_W       = LB_ADDR_W - 1;
  localparam int FB_LINE_SHIFT_HI = 7;
  localparam int FB_LINE_SHIFT_LO = 5;

endpackage

// File: rtl/fb_read_pipe.sv
// Fixed-latency tracker for outstanding framebuffer reads: carries {valid, word index}
// alongside the memory so the returning data can be steered into the line buffer.
module fb_read_pipe
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = WORD_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][IDX_W-1:0] r_idx;

  // Shift the read tags one stage per clock; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_idx   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/fb_scanline_arbiter.sv
// Arbitrates the single-port framebuffer between scanline refill reads (into a
// ping-pong line buffer) and GPU pixel writes, bounding how long a GPU write waits.
module fb_scanline_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = vga_fb_pkg::WORDS_PER_LINE,
  parameter int GPU_MAX_WAIT   = 8,
  parameter int MEM_LAT        = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 line_req,
  input  logic [8:0]           line_idx,
  output logic                 line_done,
  output logic                 overrun,
  output logic                 lb_we,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0]    lb_wdata,
  input  logic                 gpu_wr_valid,
  output logic                 gpu_wr_ready,
  input  logic [ADDR_W-1:0]    gpu_wr_addr,
  input  logic [DATA_W-1:0]    gpu_wr_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int IDX_W    = WORD_IDX_W;
  localparam int STARVE_W = (GPU_MAX_WAIT < 1) ? 1 : $clog2(GPU_MAX_WAIT + 1);
  localparam logic [IDX_W-1:0]    LAST_WORD  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(GPU_MAX_WAIT);

  fb_state_e           r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [IDX_W-1:0]    r_word, w_word_nxt;
  logic [STARVE_W-1:0] r_starve, w_starve_nxt;
  logic                r_bank, w_bank_nxt;
  logic                r_alive;

  logic [ADDR_W-1:0]   w_line_base;
  logic                w_gpu_slot;
  logic                w_rd_issue;
  logic                w_wr_issue;
  logic                w_pipe_valid;
  logic [IDX_W-1:0]    w_pipe_idx;
  logic                w_last_return;

  assign w_line_base = (ADDR_W'(line_idx) << FB_LINE_SHIFT_HI)
                     + (ADDR_W'(line_idx) << FB_LINE_SHIFT_LO);

  // Arbiter state and fetch bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_word   <= '0;
      r_starve <= '0;
      r_bank   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_base   <= w_base_nxt;
      r_word   <= w_word_nxt;
      r_starve <= w_starve_nxt;
      r_bank   <= w_bank_nxt;
    end
  end

  // Holds the GPU port closed for the first cycle after reset so all outputs start at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // Next-state, grant and read-issue decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_word_nxt   = r_word;
    w_starve_nxt = r_starve;
    w_bank_nxt   = r_bank;
    w_gpu_slot   = 1'b0;
    w_rd_issue   = 1'b0;
    gpu_wr_ready = 1'b0;
    case (r_state)
      IDLE: begin
        gpu_wr_ready = r_alive & ~line_req;
        w_starve_nxt = '0;
        if (line_req) begin
          w_base_nxt  = w_line_base;
          w_bank_nxt  = ~r_bank;
          w_word_nxt  = '0;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        w_gpu_slot   = gpu_wr_valid && (r_starve == STARVE_MAX);
        gpu_wr_ready = w_gpu_slot;
        w_rd_issue   = ~w_gpu_slot;
        // Starvation only accumulates while a write is actually waiting.
        if (!gpu_wr_valid || w_gpu_slot) begin
          w_starve_nxt = '0;
        end else if (r_starve != STARVE_MAX) begin
          w_starve_nxt = r_starve + STARVE_W'(1);
        end else begin
          w_starve_nxt = r_starve;
        end
        if (w_rd_issue) begin
          w_word_nxt = r_word + IDX_W'(1);
          if (r_word == LAST_WORD) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = FETCH;
          end
        end else begin
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        gpu_wr_ready = 1'b1;
        w_starve_nxt = '0;
        if (w_last_return) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_starve_nxt = '0;
      end
    endcase
  end

  assign w_wr_issue = gpu_wr_valid & gpu_wr_ready;

  fb_read_pipe #(
    .DEPTH (MEM_LAT),
    .IDX_W (IDX_W)
  ) u_read_pipe (
    .clk     (clk),
    .rst_n   (resetn),
    .i_valid (w_rd_issue),
    .i_idx   (r_word),
    .o_valid (w_pipe_valid),
    .o_idx   (w_pipe_idx)
  );

  assign w_last_return = w_pipe_valid && (w_pipe_idx == LAST_WORD);

  // Framebuffer port: a GPU write and a refill read never share a cycle.
  always_comb begin
    mem_en    = w_wr_issue | w_rd_issue;
    mem_we    = w_wr_issue;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_wr_issue) begin
      mem_addr  = gpu_wr_addr;
      mem_wdata = gpu_wr_data;
    end else if (w_rd_issue) begin
      mem_addr  = r_base + ADDR_W'(r_word);
    end else begin
      mem_addr  = '0;
    end
  end

  // Line-buffer side follows the read pipe output directly.
  always_comb begin
    lb_we     = w_pipe_valid;
    line_done = w_last_return;
    overrun   = line_req && (r_state != IDLE);
    lb_addr   = '0;
    lb_wdata  = '0;
    if (w_pipe_valid) begin
      lb_addr  = {r_bank, w_pipe_idx};
      lb_wdata = mem_rdata;
    end else begin
      lb_addr  = '0;
    end
  end

endmodule

// File: tb/tb_fb_scanline_arbiter.sv
// Directed bench for fb_scanline_arbiter: a fixed-latency memory model feeds reads,
// a negedge monitor logs port events, and the main sequence checks them against hand-derived values.
module tb_fb_scanline_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        line_req;
  logic [8:0]  line_idx;
  logic        line_done, overrun, lb_we;
  logic [8:0]  lb_addr;
  logic [31:0] lb_wdata;
  logic        gpu_wr_valid, gpu_wr_ready;
  logic [16:0] gpu_wr_addr;
  logic [31:0] gpu_wr_data;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam logic [16:0] GADDR = 17'h1ABCD;
  localparam logic [31:0] GDATA = 32'hFEED_BEEF;

  fb_scanline_arbiter dut (
    .clk(clk), .resetn(resetn), .line_req(line_req), .line_idx(line_idx),
    .line_done(line_done), .overrun(overrun), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .gpu_wr_valid(gpu_wr_valid), .gpu_wr_ready(gpu_wr_ready),
    .gpu_wr_addr(gpu_wr_addr), .gpu_wr_data(gpu_wr_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [16:0] a);
    return 32'hC0DE_0000 ^ {15'd0, a};
  endfunction

  // Memory model: read data appears two cycles after issue.
  logic [1:0]  mv = 2'b00;
  logic [16:0] ma0 = 17'd0, ma1 = 17'd0;
  always @(posedge clk) begin
    mv  <= {mv[0], mem_en & ~mem_we};
    ma0 <= mem_addr;
    ma1 <= ma0;
  end
  assign mem_rdata = mv[1] ? pat(ma1) : 32'd0;

  logic [16:0] rd_a[$], wr_a[$];
  logic [31:0] wr_d[$], lb_d[$];
  logic [8:0]  lb_a[$];
  int          rd_c[$], wr_c[$], lb_c[$], done_c[$], ovr_c[$];

  always @(negedge clk) begin
    if (mem_en && !mem_we) begin rd_a.push_back(mem_addr); rd_c.push_back(cyc); end
    if (mem_en && mem_we)  begin wr_a.push_back(mem_addr); wr_d.push_back(mem_wdata); wr_c.push_back(cyc); end
    if (lb_we)     begin lb_a.push_back(lb_addr); lb_d.push_back(lb_wdata); lb_c.push_back(cyc); end
    if (line_done) done_c.push_back(cyc);
    if (overrun)   ovr_c.push_back(cyc);
  end

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    lb_a.delete(); lb_d.delete(); lb_c.delete(); done_c.delete(); ovr_c.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string p, input int max_cyc);
    int k;
    k = 0;
    while (done_c.size() == 0 && k < max_cyc) begin
      step();
      k++;
    end
    chk({p, "_done_seen"}, 32'(done_c.size() > 0), 32'd1);
    step();
    step();
  endtask

  // No-GPU fetch: reads at T+1..T+160, lb writes at T+3..T+162, done at T+162.
  task automatic check_line(input string p, input int base, input int lbb, input int t0);
    int e_rd, e_lb;
    e_rd = 0;
    e_lb = 0;
    chk({p, "_rd_cnt"}, 32'(rd_a.size()), 32'd160);
    for (int i = 0; i < rd_a.size(); i++)
      if (rd_a[i] !== 17'(base + i) || rd_c[i] != t0 + 1 + i) e_rd++;
    chk({p, "_rd_seq_err"}, 32'(e_rd), 32'd0);
    chk({p, "_rd_last"}, (rd_a.size() > 0) ? 32'(rd_a[rd_a.size()-1]) : 32'hFFFF_FFFF, 32'(base + 159));
    chk({p, "_lb_cnt"}, 32'(lb_a.size()), 32'd160);
    for (int i = 0; i < lb_a.size(); i++)
      if (lb_a[i] !== 9'(lbb + i) || lb_d[i] !== pat(17'(base + i)) || lb_c[i] != t0 + 3 + i) e_lb++;
    chk({p, "_lb_seq_err"}, 32'(e_lb), 32'd0);
    chk({p, "_done_cnt"}, 32'(done_c.size()), 32'd1);
    chk({p, "_done_cyc"}, (done_c.size() > 0) ? 32'(done_c[0]) : 32'hFFFF_FFFF, 32'(t0 + 162));
  endtask

  initial begin
    int t0, e_rd, e_lb, e_wr, n_wr_fetch;
    resetn = 1'b0; line_req = 1'b0; line_idx = 9'd0;
    gpu_wr_valid = 1'b1; gpu_wr_addr = GADDR; gpu_wr_data = GDATA;
    #2;
    chk("rst_ctrl", 32'({line_done, overrun, lb_we, gpu_wr_ready, mem_en, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_lb", 32'(lb_addr) | lb_wdata, 32'd0);
    repeat (3) step();
    resetn = 1'b1;
    gpu_wr_valid = 1'b0;
    repeat (3) step();

    // Line 3, no GPU traffic, bank 1.
    clear_logs();
    line_idx = 9'd3; line_req = 1'b1; t0 = cyc;
    #1;
    chk("l3_ready_in_req", 32'(gpu_wr_ready), 32'd0);
    step(); line_req = 1'b0;
    wait_done("l3", 400);
    check_line("l3", 480, 256, t0);
    chk("l3_idle_no_lbwe", 32'(lb_we), 32'd0);
    chk("l3_idle_ready", 32'(gpu_wr_ready), 32'd1);

    // Line 0 with gpu_wr_valid held from the line_req cycle, bank 0.
    clear_logs();
    line_idx = 9'd0; line_req = 1'b1; gpu_wr_valid = 1'b1; t0 = cyc;
    #1;
    chk("g_ready_in_req", 32'(gpu_wr_ready), 32'd0);
    chk("g_memen_in_req", 32'(mem_en), 32'd0);
    step(); line_req = 1'b0;
    wait_done("g", 400);
    gpu_wr_valid = 1'b0;
    chk("g_rd_cnt", 32'(rd_a.size()), 32'd160);
    e_rd = 0;
    for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== 17'(i)) e_rd++;
    chk("g_rd_seq_err", 32'(e_rd), 32'd0);
    chk("g_rd_last_cyc", (rd_c.size() > 0) ? 32'(rd_c[rd_c.size()-1]) : 32'hFFFF_FFFF, 32'(t0 + 179));
    e_wr = 0; n_wr_fetch = 0;
    for (int i = 0; i < wr_c.size(); i++)
      if (wr_c[i] <= t0 + 179) begin
        n_wr_fetch++;
        if (wr_c[i] != t0 + 9 * (i + 1) || wr_a[i] !== GADDR || wr_d[i] !== GDATA) e_wr++;
      end
    chk("g_wr_in_fetch", 32'(n_wr_fetch), 32'd19);
    chk("g_wr_slot_err", 32'(e_wr), 32'd0);
    chk("g_first_grant", (wr_c.size() > 0) ? 32'(wr_c[0]) : 32'hFFFF_FFFF, 32'(t0 + 9));
    e_lb = 0;
    for (int i = 0; i < lb_a.size(); i++)
      if (lb_a[i] !== 9'(i) || lb_d[i] !== pat(17'(i))) e_lb++;
    chk("g_lb_cnt", 32'(lb_a.size()), 32'd160);
    chk("g_lb_seq_err", 32'(e_lb), 32'd0);
    chk("g_done_cyc", (done_c.size() > 0) ? 32'(done_c[0]) : 32'hFFFF_FFFF, 32'(t0 + 181));
    repeat (2) step();

    // Line 10 with a second line_req mid-fetch, bank 1.
    clear_logs();
    line_idx = 9'd10; line_req = 1'b1; t0 = cyc;
    step(); line_req = 1'b0;
    repeat (19) step();
    line_idx = 9'd200; line_req = 1'b1;
    #1;
    chk("ov_pulse", 32'(overrun), 32'd1);
    step(); line_req = 1'b0; line_idx = 9'd10;
    #1;
    chk("ov_drop", 32'(overrun), 32'd0);
    wait_done("ov", 400);
    check_line("ov", 1600, 256, t0);
    chk("ov_cnt", 32'(ovr_c.size()), 32'd1);

    // Line 5 interrupted by reset at word 50 (bank 0).
    clear_logs();
    line_idx = 9'd5; line_req = 1'b1; t0 = cyc;
    step(); line_req = 1'b0;
    repeat (50) step();
    chk("rs_pre_addr", 32'(mem_addr), 32'd850);
    gpu_wr_valid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rs_ctrl", 32'({line_done, overrun, lb_we, gpu_wr_ready, mem_en, mem_we}), 32'd0);
    chk("rs_addrs", 32'(mem_addr) | 32'(lb_addr), 32'd0);
    chk("rs_data", mem_wdata | lb_wdata, 32'd0);
    step(); step();
    gpu_wr_valid = 1'b0;
    resetn = 1'b1;
    clear_logs();
    repeat (10) step();
    chk("rs_no_lbwe", 32'(lb_a.size()), 32'd0);
    chk("rs_no_rd", 32'(rd_a.size()), 32'd0);

    // Line 479 after reset: bank restarts, top-of-frame address range.
    clear_logs();
    line_idx = 9'd479; line_req = 1'b1; t0 = cyc;
    step(); line_req = 1'b0;
    wait_done("l479", 400);
    check_line("l479", 76640, 256, t0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scanline_arbiter.md
# fb_scanline_arbiter

Shares the single-port framebuffer memory between display scanline refill and GPU pixel writes. On each line request from the VGA timing path, it fetches one 640-pixel line (160 words of 4×8-bit pixels) into one half of a ping-pong line buffer. GPU writes are accepted in the gaps, with a starvation limit. It sits between the 640×480 timing generator / line buffer and the GPU raster write port.

## Interface
Parameters:
- ADDR_W, 17, framebuffer word address width
- DATA_W, 32, framebuffer word width
- WORDS_PER_LINE, 160, words fetched per scanline
- GPU_MAX_WAIT, 8, maximum FETCH cycles a pending GPU write waits before it is granted
- MEM_LAT, 2, fixed framebuffer read latency in cycles (≥1)

Ports:
- clk  in  1  system clock (100 MHz)
- resetn  in  1  reset; one clock, asynchronous, active-low
- line_req  in  1  one-cycle pulse: fetch line line_idx
- line_idx  in  9  line number, 0..479
- line_done  out  1  one-cycle pulse coincident with the last lb_we of a line
- overrun  out  1  one-cycle pulse: line_req arrived while not IDLE
- lb_we  out  1  line buffer write enable
- lb_addr  out  9  {bank, word index 0..159}
- lb_wdata  out  DATA_W  line buffer write data
- gpu_wr_valid  in  1  GPU write request
- gpu_wr_ready  out  1  GPU write accepted this cycle when valid&ready
- gpu_wr_addr  in  ADDR_W  GPU write word address
- gpu_wr_data  in  DATA_W  GPU write data
- mem_en, mem_we  out  1  framebuffer enable / write
- mem_addr  out  ADDR_W  framebuffer address
- mem_wdata  out  DATA_W  framebuffer write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after a read issue

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - line_req → latch base = line_idx·128 + line_idx·32 (shift-add, ADDR_W wide, no multiplier).
  - Toggle bank (reset value 0); word counter = 0; go to FETCH.
  - gpu_wr_ready is 0 in the line_req cycle and 1 otherwise.
- FETCH:
  - Each cycle issue a read at base+word and increment word, unless the cycle is a GPU slot.
  - GPU slot: gpu_wr_valid && starve_cnt == GPU_MAX_WAIT. In a GPU slot, gpu_wr_ready=1, the write is issued, no read is issued, and starve_cnt clears.
  - starve_cnt increments (saturating) on each FETCH cycle with gpu_wr_valid && !gpu_wr_ready. It clears when gpu_wr_valid=0.
  - After the read for word WORDS_PER_LINE-1 issues, go to DRAIN.
- DRAIN:
  - No reads issue; GPU writes are granted freely.
  - Leave for IDLE in the cycle the last read returns.
- Read return pipe (depth MEM_LAT) carries valid plus word index. At its output: lb_we=1, lb_addr={bank, index}, lb_wdata=mem_rdata.
- Any memory cycle drives mem_en=1. A write also drives mem_we=1, mem_addr=gpu_wr_addr, mem_wdata=gpu_wr_data. A read drives mem_we=0, mem_addr=base+word.
- overrun: line_req in FETCH or DRAIN is ignored and pulses overrun; the in-flight fetch continues unchanged.
- Reset mid-operation: state to IDLE; counters, bank and pipe are cleared; no lb_we after reset deasserts.

## Timing
- Reset values are 0 for every output: line_done, overrun, lb_we, lb_addr, lb_wdata, gpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata.
- line_req at cycle T, no GPU traffic:
  - First read issues at T+1.
  - Last read issues at T+160.
  - First lb_we at T+1+MEM_LAT.
  - Last lb_we and line_done at T+160+MEM_LAT.
  - IDLE at T+161+MEM_LAT.
- With continuous gpu_wr_valid, one write is granted per GPU_MAX_WAIT+1 FETCH cycles. Worst-case fetch is 180 cycles for default parameters. The line period is 3200 clocks.
- gpu_wr_ready is combinational from state, starve_cnt and line_req. It does not depend on gpu_wr_addr or gpu_wr_data.
- lb_addr index increments by 1 per lb_we, in order, with no gaps other than GPU slots.

## Structure
- Package vga_fb_pkg holds:
  - the state enum (IDLE/FETCH/DRAIN)
  - WORDS_PER_LINE, LB_ADDR_W=9, FB_LINE_SHIFT constants (7, 5)
- Sub-module fb_read_pipe: MEM_LAT-deep shift register of {valid, word index}, with asynchronous active-low clear.

## Test plan
- line_req with line_idx=3, no GPU traffic:
  - reads at addresses 480..639 on consecutive cycles
  - lb_addr 256..415 (bank 1)
  - line_done exactly at T+162 for MEM_LAT=2
- gpu_wr_valid held high through a fetch of line 0:
  - exactly one write granted every 9th FETCH cycle
  - 160 reads still complete
  - no read/write issued in the same cycle
- line_req while in FETCH:
  - overrun pulses once
  - bank and addresses of the current fetch are unaffected
  - 160 lb_we total
- line_req and gpu_wr_valid in the same IDLE cycle:
  - gpu_wr_ready=0 that cycle
  - the GPU write is granted at the first GPU slot or in DRAIN
- resetn low at word 50 of a fetch:
  - all outputs go 0 immediately
  - no lb_we afterwards
  - the next line_req restarts at word 0, bank 1
- line_idx=479:
  - base 76640
  - last read address 76799
  - no address width overflow
